// File: rtl/flag_branch_unit.sv
// Flag register and branch-resolution stage downstream of the ALU: captures N/Z/V,
// resolves B/BR in decode, stalls one cycle on a flag hazard, and counts branch statistics.
module flag_branch_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_hold,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [2:0]       ex_flags,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_ccc,
    input  logic [8:0]       id_imm9,
    input  logic [15:0]      id_pc_plus2,
    input  logic [15:0]      id_rs_data,
    output logic [2:0]       flags_q,
    output logic             flag_stall,
    output logic             branch_taken,
    output logic [15:0]      branch_target,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic        writes_nzv;
    logic        writes_z;
    logic        is_br;
    logic        hazard;
    logic        cond_met;
    logic [15:0] b_target;

    always_comb begin
        writes_nzv = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
        writes_z   = (ex_opcode == OP_XOR) || (ex_opcode == OP_SLL) ||
                     (ex_opcode == OP_SRA) || (ex_opcode == OP_ROR);
        is_br      = id_valid && ((id_opcode == OP_B) || (id_opcode == OP_BR));
        hazard     = is_br && ex_valid && (writes_nzv || writes_z);
    end

    // flags_q = {N, Z, V}; Z-only writers leave N and V untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (!pipe_hold && ex_valid) begin
            if (writes_nzv) begin
                flags_q <= ex_flags;
            end else if (writes_z) begin
                flags_q[1] <= ex_flags[1];
            end
        end
    end

    always_comb begin
        cond_met = 1'b0;
        case (id_ccc)
            3'b000:  cond_met = !flags_q[1];
            3'b001:  cond_met = flags_q[1];
            3'b010:  cond_met = !flags_q[1] && !flags_q[2];
            3'b011:  cond_met = flags_q[2];
            3'b100:  cond_met = flags_q[1] || (!flags_q[1] && !flags_q[2]);
            3'b101:  cond_met = flags_q[2] || flags_q[1];
            3'b110:  cond_met = flags_q[0];
            default: cond_met = 1'b1;
        endcase
    end

    // Word offset: sign-extend imm9 and shift left by one; the add wraps modulo 2^16.
    assign b_target = id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // WAIT resolves unconditionally: the producer has left EX and its flags are in flags_q.
    always_comb begin
        state_next   = state;
        flag_stall   = 1'b0;
        branch_taken = 1'b0;
        case (state)
            S_RUN: begin
                if (hazard) begin
                    flag_stall = 1'b1;
                    if (!pipe_hold) begin
                        state_next = S_WAIT;
                    end
                end else begin
                    branch_taken = is_br && cond_met;
                end
            end
            S_WAIT: begin
                branch_taken = is_br && cond_met;
                if (!pipe_hold) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
    end

    always_comb begin
        branch_target = id_pc_plus2;
        if (branch_taken) begin
            branch_target = (id_opcode == OP_B) ? b_target : id_rs_data;
        end
        flush = branch_taken;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count    <= '0;
            taken_count <= '0;
            stall_count <= '0;
        end else if (!pipe_hold) begin
            if (is_br && !flag_stall && (br_count != CNT_MAX)) begin
                br_count <= br_count + CNT_ONE;
            end
            if (branch_taken && (taken_count != CNT_MAX)) begin
                taken_count <= taken_count + CNT_ONE;
            end
            if (flag_stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: scenario tasks drive stimulus, a negedge monitor
// pops expected {flag_stall, branch_taken, branch_target, flush} from a queue.
module tb_flag_branch_unit;

    localparam int CNT_W = 16;
    localparam int EXP_W = 19;

    logic             clk;
    logic             rst_n;
    logic             pipe_hold;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_flags;
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [2:0]       id_ccc;
    logic [8:0]       id_imm9;
    logic [15:0]      id_pc_plus2;
    logic [15:0]      id_rs_data;
    logic [2:0]       flags_q;
    logic             flag_stall;
    logic             branch_taken;
    logic [15:0]      branch_target;
    logic             flush;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] stall_count;

    flag_branch_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_flags(ex_flags),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_ccc(id_ccc),
        .id_imm9(id_imm9), .id_pc_plus2(id_pc_plus2), .id_rs_data(id_rs_data),
        .flags_q(flags_q), .flag_stall(flag_stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .flush(flush),
        .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [EXP_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [2:0]       m_flags = 3'b000;
    logic             m_wait  = 1'b0;
    logic [CNT_W-1:0] m_br = '0;
    logic [CNT_W-1:0] m_tk = '0;
    logic [CNT_W-1:0] m_st = '0;

    function automatic logic [EXP_W-1:0] model_out();
        logic is_br_m, writer, stall, taken, cond;
        logic [15:0] tgt;
        is_br_m = id_valid && (id_opcode == 4'hC || id_opcode == 4'hD);
        writer  = (ex_opcode <= 4'h1) || (ex_opcode >= 4'h3 && ex_opcode <= 4'h6);
        case (id_ccc)
            3'd0:    cond = !m_flags[1];
            3'd1:    cond = m_flags[1];
            3'd2:    cond = !m_flags[1] && !m_flags[2];
            3'd3:    cond = m_flags[2];
            3'd4:    cond = m_flags[1] || (!m_flags[1] && !m_flags[2]);
            3'd5:    cond = m_flags[2] || m_flags[1];
            3'd6:    cond = m_flags[0];
            default: cond = 1'b1;
        endcase
        stall = !m_wait && is_br_m && ex_valid && writer;
        taken = !stall && is_br_m && cond;
        tgt   = id_pc_plus2;
        if (taken) begin
            if (id_opcode == 4'hC) tgt = id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};
            else tgt = id_rs_data;
        end
        return {stall, taken, tgt, taken};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic hold, input logic exv, input logic [3:0] exop,
                         input logic [2:0] exf, input logic idv, input logic [3:0] idop,
                         input logic [2:0] ccc, input logic [8:0] imm,
                         input logic [15:0] pc, input logic [15:0] rs);
        pipe_hold = hold; ex_valid = exv; ex_opcode = exop; ex_flags = exf;
        id_valid = idv; id_opcode = idop; id_ccc = ccc; id_imm9 = imm;
        id_pc_plus2 = pc; id_rs_data = rs;
        exp_q.push_back(model_out());
    endtask

    task automatic tick();
        logic [EXP_W-1:0] e;
        logic is_br_m;
        e = model_out();
        is_br_m = id_valid && (id_opcode == 4'hC || id_opcode == 4'hD);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_flags = 3'b000; m_wait = 1'b0; m_br = '0; m_tk = '0; m_st = '0;
        end else if (!pipe_hold) begin
            if (ex_valid) begin
                if (ex_opcode <= 4'h1) m_flags = ex_flags;
                else if (ex_opcode >= 4'h3 && ex_opcode <= 4'h6) m_flags[1] = ex_flags[1];
            end
            if (is_br_m && !e[18] && m_br != {CNT_W{1'b1}}) m_br = m_br + 1'b1;
            if (e[17] && m_tk != {CNT_W{1'b1}}) m_tk = m_tk + 1'b1;
            if (e[18] && m_st != {CNT_W{1'b1}}) m_st = m_st + 1'b1;
            m_wait = m_wait ? 1'b0 : e[18];
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'b000, 9'h000, 16'h0000, 16'h0000);
        tick();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({flag_stall, branch_taken, branch_target, flush} !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got stall=%b taken=%b target=%h flush=%b, want stall=%b taken=%b target=%h flush=%b",
                         $time, flag_stall, branch_taken, branch_target, flush, e[18], e[17], e[16:1], e[0]);
            end
            checks++;
            if ({flags_q, br_count, taken_count, stall_count} !== {m_flags, m_br, m_tk, m_st}) begin
                errors++;
                $display("FAIL state @%0t: got flags=%b br=%0d tk=%0d st=%0d, want flags=%b br=%0d tk=%0d st=%0d",
                         $time, flags_q, br_count, taken_count, stall_count, m_flags, m_br, m_tk, m_st);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        pipe_hold = 1'b1; ex_valid = 1'b0; ex_opcode = 4'h0; ex_flags = 3'b111;
        id_valid = 1'b0; id_opcode = 4'h0; id_ccc = 3'b000; id_imm9 = 9'h000;
        id_pc_plus2 = 16'h0000; id_rs_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({flags_q, br_count, taken_count, stall_count, flag_stall} !== {3'b000, 48'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got flags=%b br=%0d tk=%0d st=%0d stall=%b, want all zero",
                     flags_q, br_count, taken_count, stall_count, flag_stall);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_flag_masking();
        drive(1'b0, 1'b1, 4'h0, 3'b101, 1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
        tick();
        checks++;
        if (flags_q !== 3'b101) begin
            errors++; $display("FAIL flags_add: got %b want 101", flags_q);
        end
        drive(1'b0, 1'b1, 4'h3, 3'b010, 1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
        tick();
        checks++;
        if (flags_q !== 3'b111) begin
            errors++; $display("FAIL flags_xor: got %b want 111", flags_q);
        end
        drive(1'b0, 1'b1, 4'h7, 3'b000, 1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
        tick();
        checks++;
        if (flags_q !== 3'b111) begin
            errors++; $display("FAIL flags_red: got %b want 111", flags_q);
        end
    endtask

    task automatic test_hazard_stall();
        drive(1'b0, 1'b1, 4'h1, 3'b010, 1'b1, 4'hC, 3'b001, 9'h1FF, 16'h0010, 16'h0000);
        @(negedge clk);
        checks++;
        if ({flag_stall, branch_taken} !== 2'b10) begin
            errors++; $display("FAIL hazard_stall: got stall=%b taken=%b want 1 0", flag_stall, branch_taken);
        end
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'hC, 3'b001, 9'h1FF, 16'h0010, 16'h0000);
        @(negedge clk);
        checks++;
        if ({flag_stall, branch_taken, flush, branch_target} !== {3'b011, 16'h000E}) begin
            errors++;
            $display("FAIL hazard_resolve: got stall=%b taken=%b flush=%b target=%h want 0 1 1 000e",
                     flag_stall, branch_taken, flush, branch_target);
        end
        tick();
        checks++;
        if ({stall_count, br_count} !== {16'd1, 16'd1}) begin
            errors++; $display("FAIL hazard_counts: got st=%0d br=%0d want 1 1", stall_count, br_count);
        end
    endtask

    task automatic test_conditions();
        logic [7:0] pattern;
        logic want;
        pattern = 8'b1010_1001;
        drive(1'b0, 1'b1, 4'h0, 3'b100, 1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'hD, 3'(i), 9'h0, 16'h1234, 16'hBEEF);
            @(negedge clk);
            want = pattern[i];
            checks++;
            if ({branch_taken, branch_target} !== {want, want ? 16'hBEEF : 16'h1234}) begin
                errors++;
                $display("FAIL cond_ccc%0d: got taken=%b target=%h want taken=%b", i, branch_taken, branch_target, want);
            end
            tick();
        end
    endtask

    task automatic test_wrap_and_hold();
        logic [CNT_W-1:0] s_br, s_tk, s_st;
        drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'hC, 3'b111, 9'h001, 16'hFFFE, 16'h0000);
        @(negedge clk);
        checks++;
        if ({branch_taken, branch_target} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL wrap: got taken=%b target=%h want 1 0000", branch_taken, branch_target);
        end
        tick();
        drive(1'b0, 1'b1, 4'h1, 3'b010, 1'b1, 4'hC, 3'b001, 9'h004, 16'h0100, 16'h0000);
        tick();
        s_br = br_count; s_tk = taken_count; s_st = stall_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'h0, 3'b100, 1'b1, 4'hC, 3'b001, 9'h004, 16'h0100, 16'h0000);
            @(negedge clk);
            checks++;
            if ({flag_stall, branch_taken, branch_target, br_count, taken_count, stall_count, flags_q} !==
                {2'b01, 16'h0108, s_br, s_tk, s_st, 3'b010}) begin
                errors++;
                $display("FAIL hold_%0d: got stall=%b taken=%b target=%h br=%0d tk=%0d st=%0d flags=%b",
                         i, flag_stall, branch_taken, branch_target, br_count, taken_count, stall_count, flags_q);
            end
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'hC, 3'b001, 9'h004, 16'h0100, 16'h0000);
        tick();
        checks++;
        if ({br_count, taken_count, stall_count} !== {s_br + 16'd1, s_tk + 16'd1, s_st}) begin
            errors++;
            $display("FAIL hold_release: got br=%0d tk=%0d st=%0d want %0d %0d %0d",
                     br_count, taken_count, stall_count, s_br + 16'd1, s_tk + 16'd1, s_st);
        end
        drive(1'b0, 1'b1, 4'h4, 3'b000, 1'b1, 4'hD, 3'b111, 9'h0, 16'h0200, 16'hAAAA);
        @(negedge clk);
        checks++;
        if (flag_stall !== 1'b1) begin
            errors++; $display("FAIL back_in_run: got stall=%b want 1", flag_stall);
        end
        tick();
        idle_cycle();
    endtask

    task automatic test_reset_in_wait();
        drive(1'b0, 1'b1, 4'h0, 3'b000, 1'b1, 4'hD, 3'b000, 9'h0, 16'h0300, 16'h5555);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 3'b000, 1'b1, 4'hD, 3'b000, 9'h0, 16'h0300, 16'h5555);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'hD, 3'b000, 9'h0, 16'h0300, 16'h5555);
        tick();
        checks++;
        if ({br_count, taken_count, stall_count} !== {16'd1, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL reset_wait: got br=%0d tk=%0d st=%0d want 1 1 0", br_count, taken_count, stall_count);
        end
    endtask

    task automatic test_saturation();
        int n;
        n = int'(16'hFFFF - m_tk) + 1;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'hD, 3'b111, 9'h0,
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            tick();
        end
        checks++;
        if ({br_count, taken_count} !== {16'hFFFF, 16'hFFFF}) begin
            errors++; $display("FAIL saturation: got br=%h tk=%h want ffff ffff", br_count, taken_count);
        end
    endtask

    initial begin
        test_reset();
        test_flag_masking();
        test_hazard_stall();
        test_conditions();
        test_wrap_and_hold();
        test_reset_in_wait();
        test_saturation();
        idle_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
